// File: rtl/regfile_dump_ctrl.sv
// Debug readout engine: walks a register-file index range through one read port
// and streams each captured word out on a valid/ready channel.
module regfile_dump_ctrl #(
  parameter int REGF_WIDTH = 32,
  parameter int SELECTORS  = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  abort,
  input  logic [SELECTORS-1:0]  first_idx,
  input  logic [SELECTORS-1:0]  last_idx,
  output logic [SELECTORS-1:0]  rf_sel,
  input  logic [REGF_WIDTH-1:0] rf_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [REGF_WIDTH-1:0] out_data,
  output logic [SELECTORS-1:0]  out_idx,
  output logic                  out_last,
  output logic                  busy,
  output logic                  done
);

  typedef enum logic [1:0] {IDLE, READ, SEND, DONE} state_t;

  state_t               state;
  logic [SELECTORS-1:0] cur;
  logic [SELECTORS-1:0] last_sel;

  // NOTE: all state and outputs update with non-blocking assignments so every
  // branch below reads the pre-edge values of cur/last_sel consistently.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cur       <= '0;
      last_sel  <= '0;
      rf_sel    <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_idx   <= '0;
      out_last  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else if (abort) begin
      // A word accepted in this same cycle has already been handed over.
      state     <= IDLE;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            cur      <= first_idx;
            last_sel <= last_idx;
            rf_sel   <= first_idx;
            busy     <= 1'b1;
            state    <= READ;
          end
        end
        READ: begin
          // Capture happens at the same edge as any core write, so the old value wins.
          out_data  <= rf_data;
          out_idx   <= cur;
          out_last  <= (cur == last_sel);
          out_valid <= 1'b1;
          state     <= SEND;
        end
        SEND: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            if (cur == last_sel) begin
              done  <= 1'b1;
              state <= DONE;
            end else begin
              cur    <= cur + 1'b1;
              rf_sel <= cur + 1'b1;
              state  <= READ;
            end
          end
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
